// File: rtl/sine_sample_packer.sv
// Decimates the sine generator's sample stream and locks capture to phase==0.
// Packs two samples per 32-bit word into a FIFO read over valid/ready.
// Define SINE_PACK_DROPCNT_EN to add the saturating drop_count_o counter.
module sine_sample_packer #(
  parameter int SAMPLE_W = 10,
  parameter int DECIM    = 1,
  parameter int DEPTH    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [SAMPLE_W-1:0]    phase_i,
  input  logic [SAMPLE_W-1:0]    data_sin_i,
  output logic [31:0]            out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  input  logic                   clr_ovf_i
`ifdef SINE_PACK_DROPCNT_EN
  ,
  output logic [15:0]            drop_count_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DECIM - 1);
  localparam logic [CNT_W-1:0] CNT_LOCK = (DECIM > 1) ? CNT_W'(1) : '0;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_e;

  state_e                state_q, state_d;
  logic                  lock;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  half_q, half_d;
  logic [SAMPLE_W-1:0]   s0_q, s0_d;
  logic [31:0]           mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [31:0]           out_data_q, out_data_d;
  logic                  ovf_q;
  logic                  take, push, pop, full, wr_en, drop;
  logic [31:0]           wdata;

  always_comb begin
    state_d = state_q;
    lock    = 1'b0;
    case (state_q)
      S_IDLE: if (en_i) state_d = S_ARM;
      S_ARM: begin
        if (!en_i) begin
          state_d = S_IDLE;
        end else if (phase_i == '0) begin
          state_d = S_RUN;
          lock    = 1'b1;
        end
      end
      S_RUN:   if (!en_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign take  = (state_q == S_RUN) && en_i && (cnt_q == '0);
  assign push  = take && half_q;
  assign wdata = {16'(data_sin_i), 16'(s0_q)};

  // The lock cycle itself is sample 0, so the counter starts one step ahead.
  always_comb begin
    cnt_d  = cnt_q;
    half_d = half_q;
    s0_d   = s0_q;
    if (lock) begin
      cnt_d  = CNT_LOCK;
      half_d = 1'b1;
      s0_d   = data_sin_i;
    end else if (state_q == S_RUN) begin
      if (!en_i) begin
        half_d = 1'b0;
      end else begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        if (take) begin
          half_d = !half_q;
          if (!half_q) s0_d = data_sin_i;
        end
      end
    end
  end

  assign out_valid_o = (level_q != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign full        = (level_q == LVL_FULL);
  assign wr_en       = push && (!full || pop);
  assign drop        = push && full && !pop;

  always_comb begin
    level_d = level_q;
    if (wr_en && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !wr_en) level_d = level_q - LVL_W'(1);
  end

  // Head register: a word written this edge is not yet in mem, so forward it.
  always_comb begin
    out_data_d = out_data_q;
    if (pop) begin
      if (level_q > LVL_W'(1)) out_data_d = mem_q[rd_ptr_q + PTR_W'(1)];
      else if (wr_en)          out_data_d = wdata;
    end else if (wr_en && level_q == '0) begin
      out_data_d = wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      half_q     <= 1'b0;
      s0_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      s0_q       <= s0_d;
      level_q    <= level_d;
      out_data_q <= out_data_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (drop)           ovf_q <= 1'b1;
      else if (clr_ovf_i) ovf_q <= 1'b0;
    end
  end

  assign out_data_o = out_data_q;
  assign level_o    = level_q;
  assign overflow_o = ovf_q;

`ifdef SINE_PACK_DROPCNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_ovf_i)                drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_count_o = drop_cnt_q;
`endif

endmodule
